arbitro_mult: RTL and testbench

- Round-robin arbiter and sequencer that shares one start/Fin-handshake Booth multiplier between NUM_REQ requesters.
- Latches the winning requester's operands, pulses the multiplier start, and waits for the rising edge of Fin.
- Returns the product to the winner with a one-cycle done pulse.
- A watchdog flags a multiplier that never finishes.

---
 rtl/arbitro_mult_pkg.sv | 23 ++
 rtl/arbitro_mult_if.sv | 30 +++
 rtl/arbitro_mult_rr_prioridad.sv | 37 +++
 rtl/arbitro_mult.sv | 116 +++++++++++
 tb/tb_arbitro_mult.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_mult_pkg.sv
// Shared definitions for the multiplier arbiter: default sizing and FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arbitro_mult_pkg;

  localparam int DEF_NUM_BITS = 3;
  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_TIMEOUT  = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Index width for n requesters, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_mult_if.sv
// Start/Fin handshake bus between the arbiter and the shared Booth multiplier.
// Latency: n/a (wires only).
// Backpressure: none; m_fin is a level the arbiter edge-detects.
// Ports: m_multiplicando/m_multiplicador operands, m_start one-cycle pulse,
//        m_resultado 2*NUM_BITS product, m_fin completion level.
interface arbitro_mult_if
  import arbitro_mult_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS
);

  logic [NUM_BITS-1:0]   m_multiplicando;
  logic [NUM_BITS-1:0]   m_multiplicador;
  logic                  m_start;
  logic [2*NUM_BITS-1:0] m_resultado;
  logic                  m_fin;

  // Arbiter side drives operands and start.
  modport master (
    output m_multiplicando, m_multiplicador, m_start,
    input  m_resultado, m_fin
  );

  // Multiplier side returns product and fin.
  modport slave (
    input  m_multiplicando, m_multiplicador, m_start,
    output m_resultado, m_fin
  );

endinterface

// File: rtl/arbitro_mult_rr_prioridad.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; found=0 when no request is pending.
// Ports: req (requests), ptr (search start), found (any request), idx (winner).
module rr_prioridad
  import arbitro_mult_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int               pos;
  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit to ptr wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IDX_W'(pos);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_mult.sv
// Round-robin arbiter sharing one start/Fin multiplier among NUM_REQ requesters.
// Latency: req->grant 1 cycle, ->m_start 2 cycles, done 1 cycle after Fin rise.
// Backpressure: one operation in flight; other requests wait at level in req.
// Ports: clk/reset; req, op_a, op_b from requesters; grant, done, resultado_out,
//        err to requesters; mul is the master side of the multiplier bus.
module arbitro_mult
  import arbitro_mult_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*NUM_BITS-1:0] op_a,
  input  logic [NUM_REQ*NUM_BITS-1:0] op_b,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [2*NUM_BITS-1:0]      resultado_out,
  output logic                       err,
  arbitro_mult_if.master             mul
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_BITS-1:0]   mcand_q;
  logic [NUM_BITS-1:0]   mplier_q;
  logic                  start_q;
  logic                  fin_q;
  logic [WD_W-1:0]       watchdog;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;

  rr_prioridad #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign mul.m_multiplicando = mcand_q;
  assign mul.m_multiplicador = mplier_q;
  assign mul.m_start         = start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      idx_q         <= '0;
      grant         <= '0;
      done          <= '0;
      err           <= 1'b0;
      start_q       <= 1'b0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      resultado_out <= '0;
      watchdog      <= '0;
      fin_q         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            idx_q    <= pick_idx;
            mcand_q  <= op_a[pick_idx*NUM_BITS +: NUM_BITS];
            mplier_q <= op_b[pick_idx*NUM_BITS +: NUM_BITS];
            // Registered so grant is visible during GRANT and held to RESP.
            grant    <= NUM_REQ'(1) << pick_idx;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          ptr     <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          start_q <= 1'b1;
          state   <= ST_START;
        end
        ST_START: begin
          start_q  <= 1'b0;
          watchdog <= '0;
          // Seed the edge detector so a Fin left high from the last job is not a completion.
          fin_q    <= mul.m_fin;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          fin_q    <= mul.m_fin;
          watchdog <= watchdog + 1'b1;
          if (mul.m_fin && !fin_q) begin
            resultado_out <= mul.m_resultado;
            done          <= grant;
            state         <= ST_RESP;
          end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
            resultado_out <= '0;
            err           <= 1'b1;
            done          <= grant;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          grant <= '0;
          done  <= '0;
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_mult.sv
// Directed bench for arbitro_mult with a behavioural start/Fin multiplier stub.
// Latency: n/a.
// Backpressure: n/a.
module tb_arbitro_mult;
  import arbitro_mult_pkg::*;

  localparam int NB = 3;
  localparam int NR = 4;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*NB-1:0]  op_a = '0;
  logic [NR*NB-1:0]  op_b = '0;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic [2*NB-1:0]   resultado_out;
  logic              err;

  arbitro_mult_if #(.NUM_BITS(NB)) mul ();

  arbitro_mult #(.NUM_BITS(NB), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .op_a          (op_a),
    .op_b          (op_b),
    .grant         (grant),
    .done          (done),
    .resultado_out (resultado_out),
    .err           (err),
    .mul           (mul)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Multiplier stub: product appears lat cycles after start; sticky keeps Fin high
  // until just before the next result, never suppresses Fin entirely.
  int              lat    = 3;
  bit              sticky = 1'b0;
  bit              never  = 1'b0;
  bit              busy   = 1'b0;
  bit              mdl_up = 1'b0;
  int              cnt    = 0;
  logic [NB-1:0]   ma, mb;
  int              n_start = 0;
  int              n_done  = 0;

  function automatic logic [2*NB-1:0] prod(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic signed [2*NB-1:0] sa, sb;
    sa = {{NB{a[NB-1]}}, a};
    sb = {{NB{b[NB-1]}}, b};
    return sa * sb;
  endfunction

  always @(negedge clk) begin
    if (!mdl_up) begin
      mul.m_fin       = 1'b0;
      mul.m_resultado = '0;
      mdl_up          = 1'b1;
    end
    if (mul.m_start) begin
      n_start++;
      ma   = mul.m_multiplicando;
      mb   = mul.m_multiplicador;
      cnt  = lat;
      busy = 1'b1;
      if (!sticky) mul.m_fin = 1'b0;
    end else if (busy) begin
      cnt--;
      if (cnt == 1) mul.m_fin = 1'b0;
      if (cnt == 0) begin
        busy = 1'b0;
        if (!never) begin
          mul.m_fin       = 1'b1;
          mul.m_resultado = prod(ma, mb);
        end
      end
    end else if (!sticky) begin
      mul.m_fin = 1'b0;
    end
    if (done != '0) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [NB-1:0] a, input logic [NB-1:0] b);
    op_a[r*NB +: NB] = a;
    op_b[r*NB +: NB] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic int oh2i(input logic [NR-1:0] d);
    for (int i = 0; i < NR; i++) if (d == (NR'(1) << i)) return i;
    return -1;
  endfunction

  // Waits (bounded) for a done pulse; n counts edges from the call.
  task automatic wait_done(input string tag, output int n, output logic [NR-1:0] d,
                           output logic [2*NB-1:0] r, output logic e);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      step();
      n++;
      got = (done != '0);
    end
    d = done;
    r = resultado_out;
    e = err;
    if (!got) begin
      n_chk++;
      $display("FAIL %s: no done pulse within %0d cycles", tag, n);
    end
  endtask

  int              seq_a [4] = '{0, 2, 0, 2};
  int              seq_b [5] = '{0, 1, 2, 3, 0};
  logic [2*NB-1:0] exp_p [4] = '{6'b000010, 6'b111010, 6'b001001, 6'b000100};

  initial begin
    int              n;
    int              st0;
    int              nd0;
    logic [NR-1:0]   d;
    logic [2*NB-1:0] r;
    logic            e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mstart", mul.m_start, 0);
    chk("rst_result", resultado_out, 0);
    reset = 1'b0;
    step();

    // Single requester: (-4)x(-4) = +16
    set_op(1, 3'b100, 3'b100);
    st0 = n_start;
    req = 4'b0010;
    step();
    chk("t1_grant", grant, 4'b0010);
    chk("t1_nostart", mul.m_start, 0);
    step();
    chk("t1_start", mul.m_start, 1);
    chk("t1_grant_held", grant, 4'b0010);
    req = '0;
    wait_done("t1", n, d, r, e);
    chk("t1_lat", n, 4);
    chk("t1_done", d, 4'b0010);
    chk("t1_res", r, 6'b010000);
    chk("t1_err", e, 0);
    chk("t1_nstart", n_start - st0, 1);
    step();
    chk("t1_done_clr", done, 0);
    chk("t1_grant_clr", grant, 0);
    chk("t1_res_hold", resultado_out, 6'b010000);

    // 3 x (-4) = -12; operands changed after grant must not matter
    set_op(1, 3'b011, 3'b100);
    req = 4'b0010;
    step();
    set_op(1, 3'b001, 3'b001);
    req = '0;
    wait_done("t2", n, d, r, e);
    chk("t2_lat", n, 5);
    chk("t2_done", d, 4'b0010);
    chk("t2_res", r, 6'b110100);
    step();

    // Contention: two requesters held
    do_reset();
    set_op(0, 3'b001, 3'b010);
    set_op(1, 3'b010, 3'b101);
    set_op(2, 3'b011, 3'b011);
    set_op(3, 3'b111, 3'b100);
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_done("rr2", n, d, r, e);
      chk("rr2_who", oh2i(d), seq_a[k]);
      chk("rr2_res", r, exp_p[seq_a[k]]);
    end
    req = '0;
    step();

    // Contention: all four held
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done("rr4", n, d, r, e);
      chk("rr4_who", oh2i(d), seq_b[k]);
      chk("rr4_res", r, exp_p[seq_b[k]]);
    end
    req = '0;
    step();

    // Fin left high: only a fresh rising edge completes
    sticky = 1'b1;
    set_op(0, 3'b010, 3'b011);
    req = 4'b0001;
    wait_done("stk1", n, d, r, e);
    req = '0;
    chk("stk1_res", r, 6'b000110);
    step();
    set_op(0, 3'b111, 3'b011);
    req = 4'b0001;
    wait_done("stk2", n, d, r, e);
    req = '0;
    chk("stk2_lat", n, 6);
    chk("stk2_res", r, 6'b111101);
    step();
    sticky = 1'b0;
    step();

    // Watchdog: Fin never rises
    never = 1'b1;
    set_op(2, 3'b001, 3'b001);
    req = 4'b0100;
    wait_done("tmo", n, d, r, e);
    req = '0;
    chk("tmo_lat", n, 67);
    chk("tmo_done", d, 4'b0100);
    chk("tmo_err", e, 1);
    chk("tmo_res", r, 0);
    step();
    chk("tmo_err_clr", err, 0);
    chk("tmo_done_clr", done, 0);
    never = 1'b0;
    set_op(3, 3'b110, 3'b011);
    req = 4'b1000;
    wait_done("tmo_next", n, d, r, e);
    req = '0;
    chk("tmo_next_done", d, 4'b1000);
    chk("tmo_next_res", r, 6'b111010);
    chk("tmo_next_err", e, 0);
    step();

    // Reset in the middle of WAIT, stale Fin afterwards
    lat = 10;
    set_op(0, 3'b010, 3'b010);
    req = 4'b0001;
    repeat (4) step();
    req = '0;
    reset = 1'b1;
    step();
    chk("rw_grant", grant, 0);
    chk("rw_done", done, 0);
    chk("rw_mstart", mul.m_start, 0);
    chk("rw_result", resultado_out, 0);
    reset = 1'b0;
    nd0 = n_done;
    repeat (20) step();
    chk("rw_stale", n_done - nd0, 0);
    lat = 3;
    set_op(1, 3'b101, 3'b110);
    req = 4'b0010;
    wait_done("rw_next", n, d, r, e);
    req = '0;
    chk("rw_next_lat", n, 6);
    chk("rw_next_done", d, 4'b0010);
    chk("rw_next_res", r, 6'b000110);
    step();

    // Exhaustive operand sweep with rotating requesters
    for (int i = 0; i < 64; i++) begin
      logic [NB-1:0]   a, b;
      int              ia, ib, rq;
      logic [2*NB-1:0] ex;
      a  = NB'(i >> 3);
      b  = NB'(i);
      ia = a[NB-1] ? int'(a) - 8 : int'(a);
      ib = b[NB-1] ? int'(b) - 8 : int'(b);
      ex = (2*NB)'(ia * ib);
      rq = i % NR;
      set_op(rq, a, b);
      req = NR'(1) << rq;
      wait_done("exh", n, d, r, e);
      req = '0;
      chk("exh_who", oh2i(d), rq);
      chk("exh_res", r, ex);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
